// File: rtl/seq_cmp_pkg.sv
// -----------------------------------------------------------------------------
// seq_cmp_pkg
// Shared definitions for the iterative magnitude comparator:
//   - state_e  : FSM state encoding (ST_IDLE, ST_RUN, ST_FIN)
//   - CMP_*    : one-hot cascade encoding {gt, eq, lt}
//   - cmp_decided() : true once a cascade value can no longer change
// -----------------------------------------------------------------------------
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Cascade is carried as a one-hot {gt, eq, lt} vector.
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  function automatic logic cmp_decided(input logic [2:0] casc);
    return casc[2] | casc[0];
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit.sv
// -----------------------------------------------------------------------------
// digit_comparator
// Combinational DIGIT-bit slice of a cascaded magnitude comparator.
// A decided cascade (gt or lt) from the more significant digits passes through
// untouched; only an equal cascade lets this digit decide the result.
//
// Ports:
//   a_d, b_d        : input  [DIGIT-1:0] digits of operand A and B (unsigned)
//   gt_in/eq_in/lt_in : input cascade from the more significant digits
//   gt_out/eq_out/lt_out : output cascade including this digit
// -----------------------------------------------------------------------------
module digit_comparator
  import seq_cmp_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  output logic             gt_out,
  output logic             eq_out,
  output logic             lt_out
);

  logic [2:0] w_casc_in;
  logic [2:0] w_casc_out;

  assign w_casc_in = {gt_in, eq_in, lt_in};

  always_comb begin
    w_casc_out = w_casc_in;
    if (w_casc_in == CMP_EQ) begin
      if (a_d > b_d)      w_casc_out = CMP_GT;
      else if (a_d < b_d) w_casc_out = CMP_LT;
      else                w_casc_out = CMP_EQ;
    end
  end

  assign gt_out = w_casc_out[2];
  assign eq_out = w_casc_out[1];
  assign lt_out = w_casc_out[0];

endmodule

// File: rtl/seq_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// seq_magnitude_comparator
// Iterative WIDTH-bit magnitude comparator. Operands are walked MSB-first,
// DIGIT bits per clock, with a registered gt/eq/lt cascade between cycles.
// Signed compares flip both sign bits at capture so that the unsigned walk
// yields two's-complement order.
//
// Parameters:
//   WIDTH : operand width (>= 2, multiple of DIGIT)
//   DIGIT : bits compared per cycle; NDIG = WIDTH/DIGIT cycles per compare
//
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset (aborts a compare, no done)
//   start     : request, accepted when busy=0 (IDLE or FIN)
//   is_signed : 1 = two's-complement compare; sampled with start
//   a, b      : operands; sampled with start
//   busy      : high while the digit walk is running
//   done      : one-cycle pulse, result valid
//   agb/aeb/alb : result flags, held until the next accepted start
//
// Build option:
//   SEQ_CMP_EARLY_TERM_EN : finish as soon as the cascade is decided instead
//                           of always walking all NDIG digits.
// -----------------------------------------------------------------------------
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             aeb,
  output logic             alb
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [WIDTH-1:0] map_order(input logic [WIDTH-1:0] v,
                                                  input logic            sgn);
    logic [WIDTH-1:0] r;
    r            = v;
    r[WIDTH-1]   = v[WIDTH-1] ^ sgn;
    return r;
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_casc;
  logic [IDX_W-1:0] r_idx;
  logic             r_agb;
  logic             r_aeb;
  logic             r_alb;

  logic             w_accept;
  logic             w_last;
  logic             w_run_end;
  logic [DIGIT-1:0] w_a_d;
  logic [DIGIT-1:0] w_b_d;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;
  logic [2:0]       w_casc_nxt;

  // start is ignored while the walk runs and is never queued.
  assign w_accept   = start && (r_state != ST_RUN);
  assign w_last     = (r_idx == '0);
  assign w_casc_nxt = {w_gt, w_eq, w_lt};

`ifdef SEQ_CMP_EARLY_TERM_EN
  assign w_run_end = w_last || cmp_decided(w_casc_nxt);
`else
  assign w_run_end = w_last;
`endif

  // Select the current digit from the captured operands.
  always_comb begin
    w_a_d = '0;
    w_b_d = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_d = r_a[k*DIGIT +: DIGIT];
        w_b_d = r_b[k*DIGIT +: DIGIT];
      end
    end
  end

  digit_comparator #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_d    (w_a_d),
    .b_d    (w_b_d),
    .gt_in  (r_casc[2]),
    .eq_in  (r_casc[1]),
    .lt_in  (r_casc[0]),
    .gt_out (w_gt),
    .eq_out (w_eq),
    .lt_out (w_lt)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_run_end) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_FIN);
  end

  // Operand capture and digit walk. Datapath only; meaningful after an accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a    <= map_order(a, is_signed);
      r_b    <= map_order(b, is_signed);
      r_casc <= CMP_EQ;
      r_idx  <= IDX_TOP;
    end else if (r_state == ST_RUN) begin
      r_casc <= w_casc_nxt;
      r_idx  <= r_idx - IDX_W'(1);
    end
  end

  // Result flags: cleared on accept, loaded on the edge that enters FIN so
  // they are already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_agb <= 1'b0;
      r_aeb <= 1'b0;
      r_alb <= 1'b0;
    end else if (w_accept) begin
      r_agb <= 1'b0;
      r_aeb <= 1'b0;
      r_alb <= 1'b0;
    end else if (r_state == ST_RUN && w_run_end) begin
      r_agb <= w_casc_nxt[2];
      r_aeb <= w_casc_nxt[1];
      r_alb <= w_casc_nxt[0];
    end
  end

  assign agb = r_agb;
  assign aeb = r_aeb;
  assign alb = r_alb;

endmodule
